// File: rtl/falafel_pkg.sv
// Shared falafel types: LSU request/response structs and the LSU arbiter's state encoding.
package falafel_pkg;

  localparam int unsigned N_CORES_MAX = 8;
  localparam int unsigned HEADER_W    = 16;
  localparam int unsigned DATA_W      = 32;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STORE  = 2'd1,
    LOCK   = 2'd2,
    UNLOCK = 2'd3
  } req_lsu_op_e;

  typedef struct packed {
    logic [HEADER_W-1:0] header;
    req_lsu_op_e         lsu_op;
    logic                val;
  } header_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              val;
  } header_rsp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/falafel_lsu_arbiter_if.sv
// Core-side and LSU-side handshake bundle of the falafel LSU arbiter.
interface falafel_lsu_arbiter_if #(
  parameter int unsigned N_CORES = 2
);
  import falafel_pkg::*;

  header_req_t        core_req_i [N_CORES];
  logic [N_CORES-1:0] core_ready_o;
  header_rsp_t        core_rsp_o [N_CORES];
  header_req_t        lsu_req_o;
  logic               lsu_ready_i;
  header_rsp_t        lsu_rsp_i;

  // Arbiter side.
  modport slave (
    input  core_req_i,
    output core_ready_o,
    output core_rsp_o,
    output lsu_req_o,
    input  lsu_ready_i,
    input  lsu_rsp_i
  );

  // Cores plus LSU side.
  modport master (
    output core_req_i,
    input  core_ready_o,
    input  core_rsp_o,
    input  lsu_req_o,
    output lsu_ready_i,
    output lsu_rsp_i
  );

endinterface

// File: rtl/falafel_lsu_arbiter.sv
// Lock-aware round-robin arbiter sharing one falafel LSU among N_CORES cores,
// one outstanding transaction at a time.
module falafel_lsu_arbiter
  import falafel_pkg::*;
#(
  parameter int unsigned N_CORES = 2,
  parameter int unsigned OWNER_W = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  falafel_lsu_arbiter_if.slave   bus,
  output logic                   lock_held_o,
  output logic [OWNER_W-1:0]     lock_owner_o,
  output logic                   busy_o,
  output logic                   spurious_rsp_o
);

  arb_state_e         state_q;
  logic [OWNER_W-1:0] offer_q;
  logic [OWNER_W-1:0] owner_q;
  req_lsu_op_e        op_q;
  logic               lock_held_q;
  logic [OWNER_W-1:0] lock_owner_q;

  header_req_t offered;
  logic        accept;

  function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] idx);
    return (idx == OWNER_W'(N_CORES - 1)) ? '0 : idx + OWNER_W'(1);
  endfunction

  always_comb begin
    offered        = bus.core_req_i[offer_q];
    accept         = (state_q == IDLE) && bus.lsu_ready_i && offered.val;
    bus.lsu_req_o  = (state_q == IDLE) ? offered : '0;
    spurious_rsp_o = (state_q == IDLE) && bus.lsu_rsp_i.val;
  end

  // Ready never looks at core_req_i, so a core gating val on ready cannot form a loop.
  always_comb begin
    for (int i = 0; i < int'(N_CORES); i++) begin
      bus.core_ready_o[i] = (state_q == IDLE) && bus.lsu_ready_i && (offer_q == OWNER_W'(i));
      bus.core_rsp_o[i]   = ((state_q == BUSY) && bus.lsu_rsp_i.val && (owner_q == OWNER_W'(i)))
                            ? bus.lsu_rsp_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      offer_q      <= '0;
      owner_q      <= '0;
      op_q         <= LOAD;
      lock_held_q  <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            owner_q <= offer_q;
            op_q    <= offered.lsu_op;
            state_q <= BUSY;
          end
          // A LOCK requester keeps the offer so it is still offered once the lock lands.
          if (lock_held_q) begin
            offer_q <= lock_owner_q;
          end else if (!(accept && (offered.lsu_op == LOCK))) begin
            offer_q <= wrap_inc(offer_q);
          end
        end
        BUSY: begin
          if (bus.lsu_rsp_i.val) begin
            state_q <= IDLE;
            if (op_q == LOCK) begin
              lock_held_q  <= 1'b1;
              lock_owner_q <= owner_q;
            end else if (op_q == UNLOCK) begin
              lock_held_q  <= 1'b0;
              lock_owner_q <= '0;
              offer_q      <= wrap_inc(owner_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lock_held_o  = lock_held_q;
  assign lock_owner_o = lock_owner_q;
  assign busy_o       = (state_q == BUSY);

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Scoreboard bench for falafel_lsu_arbiter: a 2-core instance for handshake/lock/reset
// scenarios and a 3-core instance for round-robin order.
module tb_falafel_lsu_arbiter;
  import falafel_pkg::*;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  falafel_lsu_arbiter_if #(.N_CORES(2)) bus2 ();
  falafel_lsu_arbiter_if #(.N_CORES(3)) bus3 ();

  logic       lock_held2, busy2, spur2;
  logic [0:0] lock_owner2;
  logic       lock_held3, busy3, spur3;
  logic [1:0] lock_owner3;

  falafel_lsu_arbiter #(.N_CORES(2)) dut2 (
    .clk_i          (clk_i),
    .rst_ni         (rst_n),
    .bus            (bus2.slave),
    .lock_held_o    (lock_held2),
    .lock_owner_o   (lock_owner2),
    .busy_o         (busy2),
    .spurious_rsp_o (spur2)
  );

  falafel_lsu_arbiter #(.N_CORES(3)) dut3 (
    .clk_i          (clk_i),
    .rst_ni         (rst_n),
    .bus            (bus3.slave),
    .lock_held_o    (lock_held3),
    .lock_owner_o   (lock_owner3),
    .busy_o         (busy3),
    .spurious_rsp_o (spur3)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Per-core expected LSU requests, and expected core responses in issue order.
  header_req_t req_sb [2][$];
  typedef struct {
    int          core;
    header_rsp_t rsp;
  } exp_rsp_t;
  exp_rsp_t rsp_sb[$];
  int order_sb[$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic put_req2(input int c, input req_lsu_op_e op, input logic [15:0] h);
    header_req_t r;
    r.header = h;
    r.lsu_op = op;
    r.val    = 1'b1;
    bus2.core_req_i[c] = r;
    req_sb[c].push_back(r);
  endtask

  // Waits for core c to be accepted; returns after the accepting edge.
  task automatic wait_accept2(input int c, input int budget, output bit ok,
                              output header_req_t seen);
    ok   = 1'b0;
    seen = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_i);
      if (bus2.core_ready_o[c] && bus2.core_req_i[c].val) begin
        ok   = 1'b1;
        seen = bus2.lsu_req_o;
        break;
      end
    end
    tick();
  endtask

  // Drives a one-cycle LSU response; c < 0 means no core should receive it.
  task automatic respond2(input int c, input logic [31:0] d, output header_rsp_t r0,
                          output header_rsp_t r1, output logic spur);
    header_rsp_t r;
    r.data = d;
    r.val  = 1'b1;
    bus2.lsu_rsp_i = r;
    if (c >= 0) rsp_sb.push_back('{core: c, rsp: r});
    @(negedge clk_i);
    r0   = bus2.core_rsp_o[0];
    r1   = bus2.core_rsp_o[1];
    spur = spur2;
    tick();
    bus2.lsu_rsp_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus2.lsu_ready_i = 1'b1;
    bus3.lsu_ready_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (bus2.core_ready_o !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_ready2: got %b want 01", bus2.core_ready_o);
    end
    vectors++;
    if ({lock_held2, lock_owner2, busy2, spur2} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_status2: got %b want 0000", {lock_held2, lock_owner2, busy2, spur2});
    end
    vectors++;
    if (bus2.lsu_req_o !== '0 || bus2.core_rsp_o[0] !== '0 || bus2.core_rsp_o[1] !== '0) begin
      miscompares++;
      $display("FAIL reset_bus2: got req %h rsp0 %h rsp1 %h want all 0", bus2.lsu_req_o,
               bus2.core_rsp_o[0], bus2.core_rsp_o[1]);
    end
    vectors++;
    if (bus3.core_ready_o !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_ready3: got %b want 001", bus3.core_ready_o);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    bit ok;
    header_req_t seen, e;
    header_rsp_t r0, r1, er;
    exp_rsp_t x;
    logic spur;
    put_req2(0, LOAD, 16'h0010);
    wait_accept2(0, 4, ok, seen);
    e = req_sb[0].pop_front();
    vectors++;
    if (!ok || seen !== e) begin
      miscompares++;
      $display("FAIL load_req: got ok=%0d %h want %h", ok, seen, e);
    end
    bus2.core_req_i[0] = '0;
    @(negedge clk_i);
    vectors++;
    if (busy2 !== 1'b1 || bus2.core_ready_o !== 2'b00 || bus2.lsu_req_o !== '0) begin
      miscompares++;
      $display("FAIL load_busy: got busy=%b ready=%b req=%h want 1 00 0", busy2,
               bus2.core_ready_o, bus2.lsu_req_o);
    end
    tick();
    tick();
    respond2(0, 32'hCAFE_0010, r0, r1, spur);
    x  = rsp_sb.pop_front();
    er = x.rsp;
    vectors++;
    if (r0 !== er || r1 !== '0) begin
      miscompares++;
      $display("FAIL load_rsp: got rsp0 %h rsp1 %h want %h 0", r0, r1, er);
    end
    @(negedge clk_i);
    vectors++;
    if (bus2.core_ready_o !== 2'b10 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL load_offer: got ready=%b busy=%b want 10 0", bus2.core_ready_o, busy2);
    end
  endtask

  task automatic test_lock();
    bit ok;
    header_req_t seen, e;
    header_rsp_t r0, r1;
    exp_rsp_t x;
    logic spur;
    tick();
    put_req2(0, LOCK, 16'h0020);
    wait_accept2(0, 4, ok, seen);
    e = req_sb[0].pop_front();
    vectors++;
    if (!ok || seen !== e) begin
      miscompares++;
      $display("FAIL lock_req: got ok=%0d %h want %h", ok, seen, e);
    end
    bus2.core_req_i[0] = '0;
    respond2(0, 32'h0000_0001, r0, r1, spur);
    x = rsp_sb.pop_front();
    vectors++;
    if (r0 !== x.rsp || r1 !== '0) begin
      miscompares++;
      $display("FAIL lock_rsp: got %h %h want %h 0", r0, r1, x.rsp);
    end
    @(negedge clk_i);
    vectors++;
    if (lock_held2 !== 1'b1 || lock_owner2 !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_held: got held=%b owner=%b want 1 0", lock_held2, lock_owner2);
    end
    put_req2(1, LOAD, 16'h0030);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      vectors++;
      if (bus2.core_ready_o[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL lock_excl cycle %0d: got ready1=%b want 0", k, bus2.core_ready_o[1]);
      end
    end
    tick();
    put_req2(0, UNLOCK, 16'h0024);
    wait_accept2(0, 4, ok, seen);
    e = req_sb[0].pop_front();
    vectors++;
    if (!ok || seen !== e) begin
      miscompares++;
      $display("FAIL unlock_req: got ok=%0d %h want %h", ok, seen, e);
    end
    bus2.core_req_i[0] = '0;
    respond2(0, 32'h0000_0002, r0, r1, spur);
    x = rsp_sb.pop_front();
    vectors++;
    if (r0 !== x.rsp || r1 !== '0) begin
      miscompares++;
      $display("FAIL unlock_rsp: got %h %h want %h 0", r0, r1, x.rsp);
    end
    @(negedge clk_i);
    e = req_sb[1].pop_front();
    vectors++;
    if (bus2.core_ready_o !== 2'b10 || bus2.lsu_req_o !== e || lock_held2 !== 1'b0) begin
      miscompares++;
      $display("FAIL unlock_handoff: got ready=%b req=%h held=%b want 10 %h 0",
               bus2.core_ready_o, bus2.lsu_req_o, lock_held2, e);
    end
    tick();
    bus2.core_req_i[1] = '0;
    respond2(1, 32'h0000_0003, r0, r1, spur);
    x = rsp_sb.pop_front();
    vectors++;
    if (r1 !== x.rsp || r0 !== '0) begin
      miscompares++;
      $display("FAIL core1_rsp: got rsp1 %h rsp0 %h want %h 0", r1, r0, x.rsp);
    end
  endtask

  task automatic test_spurious();
    header_rsp_t r0, r1;
    logic spur;
    respond2(-1, 32'hDEAD_BEEF, r0, r1, spur);
    vectors++;
    if (spur !== 1'b1 || r0 !== '0 || r1 !== '0) begin
      miscompares++;
      $display("FAIL spurious_pulse: got spur=%b rsp0 %h rsp1 %h want 1 0 0", spur, r0, r1);
    end
    @(negedge clk_i);
    vectors++;
    if (spur2 !== 1'b0 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL spurious_after: got spur=%b busy=%b want 0 0", spur2, busy2);
    end
  endtask

  task automatic test_ready_low();
    bit ok;
    header_req_t seen, e;
    header_rsp_t r0, r1;
    exp_rsp_t x;
    logic spur;
    tick();
    bus2.lsu_ready_i = 1'b0;
    put_req2(0, STORE, 16'h0040);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      vectors++;
      if (bus2.core_ready_o !== 2'b00 || busy2 !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_low cycle %0d: got ready=%b busy=%b want 00 0", k,
                 bus2.core_ready_o, busy2);
      end
    end
    tick();
    bus2.lsu_ready_i = 1'b1;
    wait_accept2(0, 2, ok, seen);
    e = req_sb[0].pop_front();
    vectors++;
    if (!ok || seen !== e) begin
      miscompares++;
      $display("FAIL ready_high_accept: got ok=%0d %h want %h", ok, seen, e);
    end
    bus2.core_req_i[0] = '0;
    @(negedge clk_i);
    vectors++;
    if (busy2 !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_high_busy: got %b want 1", busy2);
    end
    tick();
    respond2(0, 32'h0000_0004, r0, r1, spur);
    x = rsp_sb.pop_front();
    vectors++;
    if (r0 !== x.rsp || r1 !== '0) begin
      miscompares++;
      $display("FAIL ready_high_rsp: got %h %h want %h 0", r0, r1, x.rsp);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    header_req_t seen, e;
    header_rsp_t r0, r1;
    exp_rsp_t x;
    logic spur;
    tick();
    put_req2(1, LOCK, 16'h0050);
    wait_accept2(1, 4, ok, seen);
    e = req_sb[1].pop_front();
    vectors++;
    if (!ok || seen !== e) begin
      miscompares++;
      $display("FAIL c1_lock_req: got ok=%0d %h want %h", ok, seen, e);
    end
    bus2.core_req_i[1] = '0;
    respond2(1, 32'h0000_0005, r0, r1, spur);
    x = rsp_sb.pop_front();
    vectors++;
    if (r1 !== x.rsp || r0 !== '0) begin
      miscompares++;
      $display("FAIL c1_lock_rsp: got %h %h want %h 0", r1, r0, x.rsp);
    end
    put_req2(1, LOAD, 16'h0054);
    wait_accept2(1, 4, ok, seen);
    e = req_sb[1].pop_front();
    vectors++;
    if (!ok || seen !== e || lock_owner2 !== 1'b1 || lock_held2 !== 1'b1) begin
      miscompares++;
      $display("FAIL c1_locked_req: got ok=%0d %h owner=%b want %h owner 1", ok, seen,
               lock_owner2, e);
    end
    bus2.core_req_i[1] = '0;
    @(negedge clk_i);
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy2 !== 1'b0 || lock_held2 !== 1'b0 || lock_owner2 !== 1'b0 ||
        bus2.core_ready_o !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b held=%b owner=%b ready=%b want 0 0 0 01", busy2,
               lock_held2, lock_owner2, bus2.core_ready_o);
    end
    tick();
    rst_n = 1'b1;
    respond2(-1, 32'h0000_0006, r0, r1, spur);
    vectors++;
    if (spur !== 1'b1 || r0 !== '0 || r1 !== '0) begin
      miscompares++;
      $display("FAIL late_rsp: got spur=%b %h %h want 1 0 0", spur, r0, r1);
    end
  endtask

  task automatic test_round_robin();
    int got, want;
    for (int i = 0; i < 3; i++) begin
      bus3.core_req_i[i] = '{header: 16'h0100 + 16'(i), lsu_op: LOAD, val: 1'b1};
    end
    order_sb.push_back(0);
    order_sb.push_back(1);
    order_sb.push_back(2);
    order_sb.push_back(0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      got = -1;
      for (int k = 0; k < 6 && got < 0; k++) begin
        @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
          if (bus3.core_ready_o[i]) got = i;
        end
      end
      want = order_sb.pop_front();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL rr_order #%0d: got core %0d want core %0d", n, got, want);
      end
      tick();
      bus3.lsu_rsp_i = '{data: 32'h0000_0100 + 32'(n), val: 1'b1};
      tick();
      bus3.lsu_rsp_i = '0;
    end
    for (int i = 0; i < 3; i++) bus3.core_req_i[i] = '0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) bus2.core_req_i[i] = '0;
    for (int i = 0; i < 3; i++) bus3.core_req_i[i] = '0;
    bus2.lsu_ready_i = 1'b0;
    bus2.lsu_rsp_i   = '0;
    bus3.lsu_ready_i = 1'b0;
    bus3.lsu_rsp_i   = '0;
    test_reset();
    test_load();
    test_lock();
    test_spurious();
    test_ready_low();
    test_reset_mid();
    test_round_robin();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/falafel_lsu_arbiter.md
# falafel_lsu_arbiter

Shares one falafel LSU among `N_CORES` falafel allocator cores. It forwards one LSU transaction at a time and routes each response back to the core that issued the request. It is lock-aware: from the response to a core's `LOCK` until that owner's `UNLOCK` is accepted, only the owner is served. This keeps a core's alloc/free header walk atomic with respect to the other cores.

## Interface
Parameters:
- `N_CORES`, default 2: number of requesting cores, legal range 1..8.
- `OWNER_W`, default `N_CORES>1 ? $clog2(N_CORES) : 1`: width of a core index.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `core_req_i`  in  `header_req_t [N_CORES]`  per-core request (`header`, `lsu_op`, `val`).
- `core_ready_o`  out  `[N_CORES]`  per-core LSU-ready; each core sees this as its `lsu_ready_i`.
- `core_rsp_o`  out  `header_rsp_t [N_CORES]`  per-core response.
- `lsu_req_o`  out  `header_req_t`  request to the LSU.
- `lsu_ready_i`  in  1  LSU can accept a request. Must not depend combinationally on `lsu_req_o.val`.
- `lsu_rsp_i`  in  `header_rsp_t`  LSU response; `val` is a one-cycle pulse.
- `lock_held_o`  out  1  a core owns the lock.
- `lock_owner_o`  out  `OWNER_W`  index of the lock owner; 0 when no lock is held.
- `busy_o`  out  1  a transaction is outstanding.
- `spurious_rsp_o`  out  1  one-cycle pulse when `lsu_rsp_i.val` arrives in `IDLE`.

## Operation
- Registered state:
  - `state_q`: `IDLE` or `BUSY`.
  - `offer_q`: `OWNER_W` bits.
  - `owner_q`: core index of the outstanding transaction.
  - `op_q`: `req_lsu_op_e` of the outstanding transaction.
  - `lock_held_q`, `lock_owner_q`.
- Offer rule (prevents a combinational loop): `core_ready_o[i] = (state_q==IDLE) && lsu_ready_i && (i==offer_q)`. It never depends on `core_req_i`, because cores gate `val` on ready.
- `lsu_req_o`: equals `core_req_i[offer_q]` in `IDLE`, otherwise `'0`.
- Accept: occurs when `IDLE && lsu_ready_i && core_req_i[offer_q].val`.
  - Capture `owner_q<=offer_q` and `op_q<=lsu_op`.
  - Go to `BUSY`.
- Offer update in `IDLE`:
  - `lock_held_q` set: `offer_q` is forced to `lock_owner_q`.
  - Otherwise, on accept of an op other than `LOCK`: `offer_q<=offer_q+1`, wrapping at `N_CORES-1` to 0.
  - Otherwise, on accept of `LOCK`: `offer_q` is held.
  - No accept: `offer_q<=offer_q+1`, wrapping.
- `BUSY` behaviour:
  - `lsu_req_o='0` and all `core_ready_o=0`.
  - On `lsu_rsp_i.val`: drive `core_rsp_o[owner_q]=lsu_rsp_i` in the same cycle, with all other `core_rsp_o` entries `'0`, and return to `IDLE`.
  - If `op_q==LOCK`: set `lock_held_q<=1` and `lock_owner_q<=owner_q`.
  - If `op_q==UNLOCK`: clear `lock_held_q` and `lock_owner_q`, and advance `offer_q` to `owner_q+1`, wrapping.
- `UNLOCK` while no lock is held: forwarded normally, lock state unchanged.
- Non-owners are never offered while the lock is held, so they cannot `LOCK` or `UNLOCK`.
- Response in `IDLE`: dropped, `spurious_rsp_o=1` for that cycle, no state change.
- Only one transaction is outstanding; no request is forwarded while `BUSY`.

## Timing
- Reset values:
  - Registers: `state_q=IDLE`, `offer_q=0`, `owner_q=0`, `lock_held_q=0`, `lock_owner_q=0`.
  - Outputs: all outputs `0`/`'0`, except that `core_ready_o[0]` follows `lsu_ready_i` because the block is in `IDLE` with `offer_q=0`.
- Request path is combinational: an accept in cycle t puts the request on `lsu_req_o` in cycle t.
- Response path is combinational: `core_rsp_o` is valid in the same cycle as `lsu_rsp_i.val`.
- Earliest next accept: the cycle after the response.
- Worst-case offer wait with no lock held: `N_CORES` cycles.
- Reset asserted mid-transaction: all state clears immediately.
  - Lock ownership is lost.
  - A late LSU response arriving after reset is dropped and flagged `spurious_rsp_o`.
- `N_CORES==1`: `offer_q` stays 0.

## Structure
- In `falafel_pkg`:
  - Existing: `header_req_t`, `header_rsp_t`, `req_lsu_op_e`.
  - New: `arb_state_e` (`IDLE`, `BUSY`) and `N_CORES_MAX=8`.
- Single module with no sub-module. The offer pointer is a small wrap counter kept inline.

## Test plan
- 2 cores; core0 issues `LOAD` at addr `0x10` with `lsu_ready_i=1` → `lsu_req_o` carries `0x10` in the same cycle. LSU responds 3 cycles later → only `core_rsp_o[0].val=1`; `offer_q` moves to 1.
- Core0 `LOCK` accepted and responded → `lock_held_o=1`, `lock_owner_o=0`. Core1 holds `val` for 20 cycles → `core_ready_o[1]` stays 0 throughout. Core0 `UNLOCK` responded → next cycle `offer_q=1`, and core1 is accepted on its first offered cycle.
- 3 cores all requesting continuously, no locks → accepts occur in order 0,1,2,0.
- `lsu_rsp_i.val` pulse while `IDLE` → `spurious_rsp_o=1` for one cycle; every `core_rsp_o` entry stays `'0`.
- `rst_ni` asserted while `BUSY` with core1 holding the lock → `busy_o=0`, `lock_held_o=0`, `offer_q=0` immediately. A response arriving after reset is flagged spurious.
- `lsu_ready_i=0` for 5 cycles while core0 requests → no accept and no state change; the accept occurs in the first cycle that core0 is offered with `lsu_ready_i=1`.
